rv_id_issue_ctrl: RTL and testbench

Issue controller for the decode stage: owns the IF/ID valid bit, runs the valid-ready handshake towards IFU and EXU, and holds a per-register pending-write scoreboard over the regfile. An instruction in ID issues to EXU only when its sources carry no pending write and its destination counter has room. Sits beside rv_IDU; the scoreboard is released by WBU retire.

---
 rtl/rv_issue_pkg.sv | 21 ++
 rtl/rv_sb_cnt.sv | 42 ++++
 rtl/rv_id_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_rv_id_issue_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_issue_pkg.sv
// Shared sizing and types for the decode-stage issue controller and its
// per-register pending-write scoreboard.
package rv_issue_pkg;

  localparam int NREG   = 32;
  localparam int CNT_W  = 2;
  localparam int REG_AW = 5;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam cnt_t CNT_MAX = '1;

  // Why the instruction in ID is blocked; any set bit is a hazard.
  typedef struct packed {
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
  } hazard_t;

endpackage

// File: rtl/rv_sb_cnt.sv
// One scoreboard entry: saturating up/down count of in-flight writes to a
// single architectural register, with zero/full flags and underflow strobe.
module rv_sb_cnt
  import rv_issue_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output cnt_t cnt_o,
  output logic zero_o,
  output logic full_o,
  output logic unf_o
);

  cnt_t cnt_q;
  cnt_t cnt_d;

  // Simultaneous inc and dec cancel; the bounds never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign full_o = (cnt_q == CNT_MAX);
  assign unf_o  = dec_i & (cnt_q == '0);

endmodule

// File: rtl/rv_id_issue_ctrl.sv
// Decode-stage issue controller: IF/ID valid bit, IFU/EXU handshakes and the
// pending-write scoreboard. Define RV_ISSUE_WB_BYPASS_EN to let a same-cycle
// retire of the last pending write satisfy a source (write-first regfile).
module rv_id_issue_ctrl
  import rv_issue_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           if_valid,
  output logic           if_ready,
  input  reg_idx_t       id_rs1,
  input  reg_idx_t       id_rs2,
  input  reg_idx_t       id_rd,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic           id_rf_we,
  output logic           ex_valid,
  input  logic           ex_ready,
  input  logic           wb_valid,
  input  logic           wb_we,
  input  reg_idx_t       wb_rd,
  input  logic           flush,
  output logic           stall_raw,
  output logic [31:0]    stall_cycles,
  output logic           sb_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ex_valid never depends on ex_ready, if_ready may depend on it.
  logic        id_vld_q, id_vld_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        sb_err_q, sb_err_d;

  logic        ex_fire, if_fire;
  logic        inc_en, dec_en;
  logic        rs1_byp, rs2_byp;
  hazard_t     haz;
  logic        hazard;

  cnt_t            cnt      [NREG];
  logic [NREG-1:0] zero_vec;
  logic [NREG-1:0] full_vec;
  logic [NREG-1:0] unf_vec;

  // x0 is hard-wired: always idle, never full, never underflows.
  assign cnt[0]      = '0;
  assign zero_vec[0] = 1'b1;
  assign full_vec[0] = 1'b0;
  assign unf_vec[0]  = 1'b0;

  assign inc_en = ex_fire & id_rf_we & (id_rd != '0);
  assign dec_en = wb_valid & wb_we & (wb_rd != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    rv_sb_cnt u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc_en & (id_rd == reg_idx_t'(r))),
      .dec_i  (dec_en & (wb_rd == reg_idx_t'(r))),
      .cnt_o  (cnt[r]),
      .zero_o (zero_vec[r]),
      .full_o (full_vec[r]),
      .unf_o  (unf_vec[r])
    );
  end

`ifdef RV_ISSUE_WB_BYPASS_EN
  assign rs1_byp = dec_en & (wb_rd == id_rs1) & (cnt[id_rs1] == cnt_t'(1));
  assign rs2_byp = dec_en & (wb_rd == id_rs2) & (cnt[id_rs2] == cnt_t'(1));
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;

  // Counter values only matter for the bypass qualifier.
  logic cnt_unused;
  always_comb begin
    cnt_unused = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      cnt_unused = cnt_unused ^ (^cnt[r]);
    end
  end
`endif

  always_comb begin
    haz.rs1_busy = id_use_rs1 & (id_rs1 != '0) & ~zero_vec[id_rs1] & ~rs1_byp;
    haz.rs2_busy = id_use_rs2 & (id_rs2 != '0) & ~zero_vec[id_rs2] & ~rs2_byp;
    haz.rd_full  = id_rf_we & (id_rd != '0) & full_vec[id_rd];
    hazard       = |haz;
  end

  assign ex_valid  = id_vld_q & ~hazard & ~flush;
  assign stall_raw = id_vld_q & hazard & ~flush;
  assign ex_fire   = ex_valid & ex_ready;
  assign if_ready  = ~flush & (~id_vld_q | ex_fire);
  assign if_fire   = if_valid & if_ready;

  always_comb begin
    id_vld_d = id_vld_q;
    if (flush) begin
      id_vld_d = 1'b0;
    end else if (if_fire) begin
      id_vld_d = 1'b1;
    end else if (ex_fire) begin
      id_vld_d = 1'b0;
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, stall_raw};
  assign sb_err_d    = sb_err_q | (|unf_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_vld_q    <= 1'b0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      id_vld_q    <= id_vld_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_rv_id_issue_ctrl.sv
// Directed bench for rv_id_issue_ctrl: expected issue cycles are queued when
// an instruction is offered and popped when the DUT fires towards EXU.
module tb_rv_id_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_rf_we;
  logic        ex_valid;
  logic        ex_ready;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall_raw;
  logic [31:0] stall_cycles;
  logic        sb_err;

  int          errors;
  int          checks;
  int          cyc;
  int          exp_stalls;
  logic [31:0] exp_q[$];

  rv_id_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rf_we     (id_rf_we),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .stall_raw    (stall_raw),
    .stall_cycles (stall_cycles),
    .sb_err       (sb_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Checking and driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic we);
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_rf_we = we;
  endtask

  task automatic offer(input logic v);
    if_valid = v;
  endtask

  task automatic retire(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_we = v; wb_rd = rd;
  endtask

  // Checks this cycle's stall/issue outputs, scores any issue, advances a clock.
  task automatic end_cycle(input logic exp_stall, input logic exp_exv);
    #1;
    chk("stall_raw", {31'd0, stall_raw}, {31'd0, exp_stall});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, exp_exv});
    if (exp_stall) exp_stalls++;
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL issue_unexpected: fired at cycle %0d, expected no issue", cyc);
      end else begin
        chk("issue_cycle", cyc, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; exp_stalls = 0;
    rst = 1'b0;
    if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    retire(1'b0, 5'd0);

    // Reset values
    #12;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_stall_raw", {31'd0, stall_raw}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err}, 32'd0);
    #11;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Independent stream: one issue per cycle, never a stall
    offer(1'b1);
    #1;
    chk("stream_if_ready_empty", {31'd0, if_ready}, 32'd1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      set_id(5'($urandom_range(1, 4)), 5'($urandom_range(1, 4)), 5'(10 + i),
             1'b1, 1'($urandom_range(0, 1)), 1'b1);
      offer(i < 5);
      if (i < 5) exp_q.push_back(cyc + 1);
      end_cycle(1'b0, 1'b1);
    end
    offer(1'b0);
    for (int i = 0; i < 6; i++) begin
      retire(1'b1, 5'(10 + i));
      end_cycle(1'b0, 1'b0);
    end
    retire(1'b0, 5'd0);
    chk("stream_stall_cycles", stall_cycles, 32'd0);
    chk("stream_sb_err", {31'd0, sb_err}, 32'd0);

    // RAW: add x5,x1,x2 then add x6,x5,x1
    offer(1'b1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    set_id(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
    offer(1'b1);
    end_cycle(1'b0, 1'b1);
    set_id(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1);
    offer(1'b0);
    for (int k = 0; k < 3; k++) end_cycle(1'b1, 1'b0);
    retire(1'b1, 5'd5);
`ifdef RV_ISSUE_WB_BYPASS_EN
    exp_q.push_back(cyc);
    end_cycle(1'b0, 1'b1);
    retire(1'b0, 5'd0);
`else
    end_cycle(1'b1, 1'b0);
    retire(1'b0, 5'd0);
    exp_q.push_back(cyc);
    end_cycle(1'b0, 1'b1);
`endif
    chk("raw_stall_cycles", stall_cycles, exp_stalls);
    retire(1'b1, 5'd6);
    end_cycle(1'b0, 1'b0);
    retire(1'b0, 5'd0);

    // Three writes to x7 fill its counter; the fourth waits for one retire
    offer(1'b1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_id(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
      offer(1'b1);
      if (i < 2) exp_q.push_back(cyc + 1);
      end_cycle(1'b0, 1'b1);
    end
    offer(1'b0);
    end_cycle(1'b1, 1'b0);
    end_cycle(1'b1, 1'b0);
    retire(1'b1, 5'd7);
    end_cycle(1'b1, 1'b0);
    retire(1'b0, 5'd0);
    exp_q.push_back(cyc);
    end_cycle(1'b0, 1'b1);

    // x0 writes are untracked; lui ignores a busy rs1 field
    offer(1'b1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_id(5'($urandom_range(1, 4)), 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      else       set_id(5'd7, 5'd7, 5'd8, 1'b0, 1'b0, 1'b1);
      offer(i < 4);
      if (i < 4) exp_q.push_back(cyc + 1);
      end_cycle(1'b0, 1'b1);
    end
    offer(1'b0);

    // Flush while stalled on x7 kills the instruction and blocks the offer
    offer(1'b1);
    end_cycle(1'b0, 1'b0);
    set_id(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
    offer(1'b0);
    end_cycle(1'b1, 1'b0);
    flush = 1'b1;
    offer(1'b1);
    #1;
    chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
    end_cycle(1'b0, 1'b0);
    flush = 1'b0;
    offer(1'b0);
    #1;
    chk("post_flush_if_ready", {31'd0, if_ready}, 32'd1);
    end_cycle(1'b0, 1'b0);

    // x7 still holds three pending writes: two retires leave it busy
    for (int k = 0; k < 2; k++) begin
      retire(1'b1, 5'd7);
      end_cycle(1'b0, 1'b0);
    end
    retire(1'b0, 5'd0);
    offer(1'b1);
    end_cycle(1'b0, 1'b0);
    offer(1'b0);
    end_cycle(1'b1, 1'b0);
    retire(1'b1, 5'd7);
`ifdef RV_ISSUE_WB_BYPASS_EN
    exp_q.push_back(cyc);
    end_cycle(1'b0, 1'b1);
    retire(1'b0, 5'd0);
`else
    end_cycle(1'b1, 1'b0);
    retire(1'b0, 5'd0);
    exp_q.push_back(cyc);
    end_cycle(1'b0, 1'b1);
`endif
    retire(1'b1, 5'd8);
    end_cycle(1'b0, 1'b0);
    retire(1'b1, 5'd11);
    end_cycle(1'b0, 1'b0);
    retire(1'b0, 5'd0);
    chk("mid_stall_cycles", stall_cycles, exp_stalls);
    chk("pre_err_sb_err", {31'd0, sb_err}, 32'd0);

    // Retire to idle x9 raises sticky sb_err
    retire(1'b1, 5'd9);
    end_cycle(1'b0, 1'b0);
    retire(1'b0, 5'd0);
    chk("sb_err_set", {31'd0, sb_err}, 32'd1);
    end_cycle(1'b0, 1'b0);
    end_cycle(1'b0, 1'b0);
    chk("sb_err_sticky", {31'd0, sb_err}, 32'd1);

    // Reset while stalled on x12 clears everything at once
    offer(1'b1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    set_id(5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
    offer(1'b1);
    end_cycle(1'b0, 1'b1);
    set_id(5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1);
    offer(1'b0);
    #1;
    chk("pre_rst_stall_raw", {31'd0, stall_raw}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_stall_raw", {31'd0, stall_raw}, 32'd0);
    chk("async_rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("async_rst_stall_cycles", stall_cycles, 32'd0);
    chk("async_rst_sb_err", {31'd0, sb_err}, 32'd0);
    exp_stalls = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    offer(1'b1);
    exp_q.push_back(cyc + 1);
    end_cycle(1'b0, 1'b0);
    offer(1'b0);
    end_cycle(1'b0, 1'b1);
    chk("post_rst_stall_cycles", stall_cycles, exp_stalls);
    chk("post_rst_sb_err", {31'd0, sb_err}, 32'd0);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
